// File: rtl/aes_iterative_core.sv
// Iterative AES-128/192/256 core. The key is expanded one word per cycle into a
// round-key register file, and one shared round datapath encrypts or decrypts.
module aes_iterative_core #(
   parameter int NK = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [32*NK-1:0]  KeyIn,
   input  logic              KeyValid,
   output logic              KeyReady,
   input  logic [127:0]      DataIn,
   input  logic              Mode,
   input  logic              InValid,
   output logic              InReady,
   output logic [127:0]      DataOut,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              KeyLoaded
);
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam logic [3:0] NR_L    = 4'(NR);
   localparam logic [5:0] LAST_W  = 6'(NW - 1);
   localparam logic [2:0] NK_LAST = 3'(NK - 1);

   generate
      if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
         $error("aes_iterative_core: NK must be 4, 6 or 8");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, KEXP, READY, RUN, HOLD} fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x7   = gf_mul(x6, x);
      x14  = gf_mul(x7, x7);
      x15  = gf_mul(x14, x);
      x30  = gf_mul(x15, x15);
      x31  = gf_mul(x30, x);
      x62  = gf_mul(x31, x31);
      x63  = gf_mul(x62, x);
      x126 = gf_mul(x63, x63);
      x127 = gf_mul(x126, x);
      return gf_mul(x127, x127);
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] y;
      y = gf_inv(x);
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
               ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      logic [7:0] b;
      b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
   endfunction

   // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      int src;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0]   acc;
      logic [7:0]   coef;
      int k;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               k = (j - i + 4) % 4;
               case (k)
                  0:       coef = inv ? 8'h0e : 8'h02;
                  1:       coef = inv ? 8'h0b : 8'h03;
                  2:       coef = inv ? 8'h0d : 8'h01;
                  default: coef = inv ? 8'h09 : 8'h01;
               endcase
               acc = acc ^ gf_mul(coef, s[127 - 8*(4*c + j) -: 8]);
            end
            o[127 - 8*(4*c + i) -: 8] = acc;
         end
      end
      return o;
   endfunction

   fsm_t          fsm_q, fsm_d;
   logic          key_ready_q, key_ready_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          key_loaded_q, key_loaded_d;
   logic [127:0]  data_out_q, data_out_d;
   logic [127:0]  blk_q, blk_d;
   logic [3:0]    r_q, r_d;
   logic          mode_q, mode_d;
   logic [5:0]    widx_q, widx_d;
   logic [2:0]    kmod_q, kmod_d;
   logic [7:0]    rcon_q, rcon_d;
   logic [31:0]   win_q [NK];
   logic [31:0]   win_d [NK];
   logic [31:0]   rk_q [NW];

   logic          key_hs, blk_hs, key_load, rk_we;
   logic [31:0]   prev_w, t_w, new_w;
   logic [3:0]    rk_idx;
   logic [5:0]    rk_base;
   logic [127:0]  rk_blk;
   logic [127:0]  sub_fwd, sub_inv;
   logic [127:0]  enc_sr, enc_mc, dec_ark, round_out;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
         assign sub_fwd[8*gi +: 8] = sbox_fwd(blk_q[8*gi +: 8]);
         assign sub_inv[8*gi +: 8] = sbox_inv(blk_q[8*gi +: 8]);
      end
   endgenerate

   // The read port serves the initial whitening in READY and the rounds in RUN.
   always_comb begin
      if (fsm_q == READY) rk_idx = Mode ? NR_L : 4'd0;
      else                rk_idx = mode_q ? (NR_L - r_q) : r_q;
      rk_base = {rk_idx, 2'b00};
      rk_blk  = {rk_q[rk_base], rk_q[rk_base + 6'd1], rk_q[rk_base + 6'd2], rk_q[rk_base + 6'd3]};
   end

   always_comb begin
      enc_sr  = shift_rows(sub_fwd, 1'b0);
      enc_mc  = (r_q == NR_L) ? enc_sr : mix_columns(enc_sr, 1'b0);
      dec_ark = shift_rows(sub_inv, 1'b1) ^ rk_blk;
      if (mode_q) round_out = (r_q == NR_L) ? dec_ark : mix_columns(dec_ark, 1'b1);
      else        round_out = enc_mc ^ rk_blk;
   end

   // win_q[0] is w[i-NK], win_q[NK-1] is w[i-1].
   always_comb begin
      prev_w = win_q[NK-1];
      if (kmod_q == 3'd0)
         t_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h000000};
      else if (NK == 8 && kmod_q == 3'd4)
         t_w = sub_word(prev_w);
      else
         t_w = prev_w;
      new_w = win_q[0] ^ t_w;
   end

   always_comb begin
      fsm_d        = fsm_q;
      blk_d        = blk_q;
      r_d          = r_q;
      mode_d       = mode_q;
      widx_d       = widx_q;
      kmod_d       = kmod_q;
      rcon_d       = rcon_q;
      key_loaded_d = key_loaded_q;
      out_valid_d  = out_valid_q;
      data_out_d   = data_out_q;
      key_load     = 1'b0;
      rk_we        = 1'b0;
      for (int j = 0; j < NK; j++) win_d[j] = win_q[j];
      // A key offer always takes priority over a block offered in the same cycle.
      key_hs = KeyValid & key_ready_q;
      blk_hs = InValid & in_ready_q & ~KeyValid;

      case (fsm_q)
         IDLE, READY: begin
            if (key_hs) begin
               key_load = 1'b1;
               for (int j = 0; j < NK; j++) win_d[j] = KeyIn[32*(NK-j)-1 -: 32];
               widx_d       = 6'(NK);
               kmod_d       = 3'd0;
               rcon_d       = 8'h01;
               key_loaded_d = 1'b0;
               fsm_d        = KEXP;
            end else if (blk_hs) begin
               mode_d = Mode;
               blk_d  = DataIn ^ rk_blk;
               r_d    = 4'd1;
               fsm_d  = RUN;
            end
         end
         KEXP: begin
            rk_we = 1'b1;
            for (int j = 0; j < NK - 1; j++) win_d[j] = win_q[j+1];
            win_d[NK-1] = new_w;
            if (kmod_q == 3'd0) rcon_d = xtime(rcon_q);
            kmod_d = (kmod_q == NK_LAST) ? 3'd0 : kmod_q + 3'd1;
            if (widx_q == LAST_W) begin
               key_loaded_d = 1'b1;
               fsm_d        = READY;
            end else begin
               widx_d = widx_q + 6'd1;
            end
         end
         RUN: begin
            blk_d = round_out;
            if (r_q == NR_L) begin
               data_out_d  = round_out;
               out_valid_d = 1'b1;
               fsm_d       = HOLD;
            end else begin
               r_d = r_q + 4'd1;
            end
         end
         HOLD: begin
            if (OutReady) begin
               out_valid_d = 1'b0;
               fsm_d       = READY;
            end
         end
         default: fsm_d = IDLE;
      endcase

      key_ready_d = (fsm_d == IDLE) || (fsm_d == READY);
      in_ready_d  = (fsm_d == READY);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         fsm_q        <= IDLE;
         key_ready_q  <= 1'b0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         key_loaded_q <= 1'b0;
         data_out_q   <= '0;
      end else begin
         fsm_q        <= fsm_d;
         key_ready_q  <= key_ready_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         key_loaded_q <= key_loaded_d;
         data_out_q   <= data_out_d;
      end
   end

   always_ff @(posedge Clk) begin
      blk_q  <= blk_d;
      r_q    <= r_d;
      mode_q <= mode_d;
      widx_q <= widx_d;
      kmod_q <= kmod_d;
      rcon_q <= rcon_d;
      win_q  <= win_d;
   end

   always_ff @(posedge Clk) begin
      if (key_load) begin
         for (int j = 0; j < NK; j++) rk_q[j] <= KeyIn[32*(NK-j)-1 -: 32];
      end else if (rk_we) begin
         rk_q[widx_q] <= new_w;
      end
   end

   assign KeyReady  = key_ready_q;
   assign InReady   = in_ready_q;
   assign OutValid  = out_valid_q;
   assign KeyLoaded = key_loaded_q;
   assign DataOut   = data_out_q;

endmodule

// File: tb/tb_aes_iterative_core.sv
// Directed bench for aes_iterative_core: three instances (NK=4/6/8) driven from
// a vector table plus hand-written backpressure, reset and key-change sequences.
module tb_aes_iterative_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         out_ready;
   logic [255:0] key_in;
   logic [127:0] data_in;
   logic         mode;
   logic [2:0]   key_valid, in_valid;
   logic [2:0]   key_ready, in_ready, out_valid, key_loaded;
   logic [127:0] data_out [3];

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] KB  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K4  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K6  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   aes_iterative_core #(.NK(4)) dut4 (
      .Clk(clk), .Rst(rst), .KeyIn(key_in[255:128]), .KeyValid(key_valid[0]),
      .KeyReady(key_ready[0]), .DataIn(data_in), .Mode(mode), .InValid(in_valid[0]),
      .InReady(in_ready[0]), .DataOut(data_out[0]), .OutValid(out_valid[0]),
      .OutReady(out_ready), .KeyLoaded(key_loaded[0])
   );
   aes_iterative_core #(.NK(6)) dut6 (
      .Clk(clk), .Rst(rst), .KeyIn(key_in[255:64]), .KeyValid(key_valid[1]),
      .KeyReady(key_ready[1]), .DataIn(data_in), .Mode(mode), .InValid(in_valid[1]),
      .InReady(in_ready[1]), .DataOut(data_out[1]), .OutValid(out_valid[1]),
      .OutReady(out_ready), .KeyLoaded(key_loaded[1])
   );
   aes_iterative_core #(.NK(8)) dut8 (
      .Clk(clk), .Rst(rst), .KeyIn(key_in), .KeyValid(key_valid[2]),
      .KeyReady(key_ready[2]), .DataIn(data_in), .Mode(mode), .InValid(in_valid[2]),
      .InReady(in_ready[2]), .DataOut(data_out[2]), .OutValid(out_valid[2]),
      .OutReady(out_ready), .KeyLoaded(key_loaded[2])
   );

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      int           d;
      logic         ld;
      logic [255:0] key;
      int           klat;
      logic         m;
      logic [127:0] din;
      logic [127:0] dout;
      int           lat;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic load_key(input int d, input logic [255:0] k, output int lat);
      int n;
      key_in       = k;
      key_valid[d] = 1'b1;
      n = 0;
      while (!key_ready[d] && n < 100) begin step(); n++; end
      step();
      key_valid[d] = 1'b0;
      lat = 0;
      while (!key_loaded[d] && lat < 200) begin step(); lat++; end
   endtask

   task automatic run_block(input int d, input logic m, input logic [127:0] din,
                            output logic [127:0] dout, output int lat);
      int n;
      data_in     = din;
      mode        = m;
      in_valid[d] = 1'b1;
      n = 0;
      while (!in_ready[d] && n < 100) begin step(); n++; end
      step();
      in_valid[d] = 1'b0;
      lat = 0;
      while (!out_valid[d] && lat < 100) begin step(); lat++; end
      dout      = data_out[d];
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           klat, lat, n;
      logic [127:0] res;
      logic         stable, seen;

      vecs[0] = '{0, 1'b0, KB, 40, 1'b0, PTB, CTB, 10};
      vecs[1] = '{0, 1'b0, KB, 40, 1'b1, CTB, PTB, 10};
      vecs[2] = '{0, 1'b1, K4, 40, 1'b0, PT,  CT4, 10};
      vecs[3] = '{0, 1'b0, K4, 40, 1'b1, CT4, PT,  10};
      vecs[4] = '{1, 1'b1, K6, 46, 1'b0, PT,  CT6, 12};
      vecs[5] = '{1, 1'b0, K6, 46, 1'b1, CT6, PT,  12};
      vecs[6] = '{2, 1'b1, K8, 52, 1'b0, PT,  CT8, 14};
      vecs[7] = '{2, 1'b0, K8, 52, 1'b1, CT8, PT,  14};

      rst = 1'b1; out_ready = 1'b0; key_in = '0; data_in = '0; mode = 1'b0;
      key_valid = 3'b000; in_valid = 3'b000;
      repeat (3) step();
      check("reset KeyReady", key_ready[0], 0);
      check("reset InReady", in_ready[0], 0);
      check("reset OutValid", out_valid[0], 0);
      check("reset KeyLoaded", key_loaded[0], 0);
      check("reset DataOut", data_out[0], 0);
      rst = 1'b0;
      step();
      check("idle KeyReady", key_ready[0], 1);

      load_key(0, KB, klat);
      check("kexp128 latency", klat, 40);
      check("kexp128 w43", dut4.rk_q[43], 32'hb6630ca6);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].ld) begin
            load_key(vecs[i].d, vecs[i].key, klat);
            check($sformatf("vec%0d key latency", i), klat, vecs[i].klat);
         end
         run_block(vecs[i].d, vecs[i].m, vecs[i].din, res, lat);
         check($sformatf("vec%0d dout", i), res, vecs[i].dout);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d OutValid drop", i), out_valid[vecs[i].d], 0);
      end

      // Backpressure: dut4 holds key K4 at this point.
      data_in = PT; mode = 1'b0; in_valid[0] = 1'b1;
      n = 0;
      while (!in_ready[0] && n < 100) begin step(); n++; end
      step();
      lat = 0;
      while (!out_valid[0] && lat < 100) begin step(); lat++; end
      check("bp latency", lat, 10);
      stable = 1'b1; seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (data_out[0] !== CT4 || out_valid[0] !== 1'b1) stable = 1'b0;
         if (in_ready[0] !== 1'b0) seen = 1'b1;
      end
      check("bp DataOut/OutValid stable", stable, 1);
      check("bp InReady seen high", seen, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp OutValid drop", out_valid[0], 0);
      check("bp InReady after drop", in_ready[0], 1);
      step();
      check("bp next block accepted", in_ready[0], 0);
      in_valid[0] = 1'b0;
      lat = 0;
      while (!out_valid[0] && lat < 100) begin step(); lat++; end
      check("bp second latency", lat, 10);
      check("bp second dout", data_out[0], CT4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Reset during round 5.
      data_in = PT; mode = 1'b0; in_valid[0] = 1'b1;
      n = 0;
      while (!in_ready[0] && n < 100) begin step(); n++; end
      step();
      in_valid[0] = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      check("rst OutValid", out_valid[0], 0);
      check("rst KeyLoaded", key_loaded[0], 0);
      check("rst InReady", in_ready[0], 0);
      rst = 1'b0;
      step();
      check("post-rst KeyReady (idle)", key_ready[0], 1);
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) seen = 1'b1;
      end
      check("post-rst no output, no InReady", seen, 0);
      load_key(0, K4, klat);
      check("reload key latency", klat, 40);
      run_block(0, 1'b0, PT, res, lat);
      check("post-rst dout", res, CT4);
      check("post-rst latency", lat, 10);

      // Simultaneous key and block offer in READY: the key wins.
      check("kc InReady before", in_ready[0], 1);
      key_in = KB; key_valid[0] = 1'b1;
      data_in = PTB; mode = 1'b0; in_valid[0] = 1'b1;
      step();
      key_valid[0] = 1'b0;
      check("kc InReady after offer", in_ready[0], 0);
      check("kc KeyLoaded cleared", key_loaded[0], 0);
      klat = 0;
      while (!key_loaded[0] && klat < 200) begin
         step();
         klat++;
      end
      check("kc key latency", klat, 40);
      check("kc OutValid quiet", out_valid[0], 0);
      step();
      in_valid[0] = 1'b0;
      lat = 0;
      while (!out_valid[0] && lat < 100) begin step(); lat++; end
      check("kc dout under new key", data_out[0], CTB);
      check("kc latency", lat, 10);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
